// File: rtl/dla_cdc_pkg.sv
// Shared types for the dla clock-crossing handshake blocks.
// Holds the destination FSM encoding and counter width.
package dla_cdc_pkg;

  localparam int SETTLE_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACK    = 2'd2
  } dla_cdc_hs_dst_state_t;

endpackage

// File: rtl/dla_clock_cross_handshake_dst.sv
// Destination side of a 4-phase req/ack multi-bit clock crossing.
// Samples bundled data after settle, holds it in a 1-entry valid/ready slot.
module dla_clock_cross_handshake_dst
  import dla_cdc_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_dst,
  input  logic             i_dst_async_resetn,
  input  logic             i_req_sync,
  input  logic [WIDTH-1:0] i_src_data,
  output logic             o_ack,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic             o_error
);

  dla_cdc_hs_dst_state_t   state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    capture;
  logic                    err_set;
  logic                    slot_free;

  assign slot_free = !o_valid || i_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_sync) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_CNT_W'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        // Request vanishing before capture is a source protocol violation
        if (!i_req_sync) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - SETTLE_CNT_W'(1);
        end else if (slot_free) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!i_req_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_dst or negedge i_dst_async_resetn) begin
    if (!i_dst_async_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_ack   <= 1'b0;
      o_error <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_ack   <= (state_d == ACK);
      o_error <= o_error | err_set;
    end
  end

  // Capture wins over drain so a same-edge refill leaves no bubble
  always_ff @(posedge clk_dst or negedge i_dst_async_resetn) begin
    if (!i_dst_async_resetn) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (capture) begin
      o_valid <= 1'b1;
      o_data  <= i_src_data;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
